// File: rtl/act_buf_scheduler_if.sv
// act_buf_scheduler_if: host write, tile command, buffer port and array stream signals of the activation buffer scheduler.
interface act_buf_scheduler_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_ACTIVATIONS = 256
);
  localparam int ADDR_W = $clog2(NUM_ACTIVATIONS);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_base;
  logic [ADDR_W:0]       cmd_len;
  logic                  stall;
  logic                  buf_load_enable;
  logic [ADDR_W-1:0]     buf_load_addr;
  logic [DATA_WIDTH-1:0] buf_load_data;
  logic                  buf_read_enable;
  logic [ADDR_W-1:0]     buf_read_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  modport slave (
    input  wr_valid, wr_addr, wr_data, cmd_valid, cmd_base, cmd_len, stall, buf_data,
    output wr_ready, cmd_ready, buf_load_enable, buf_load_addr, buf_load_data,
           buf_read_enable, buf_read_addr, out_valid, out_data, out_last, busy, done
  );
  modport master (
    output wr_valid, wr_addr, wr_data, cmd_valid, cmd_base, cmd_len, stall, buf_data,
    input  wr_ready, cmd_ready, buf_load_enable, buf_load_addr, buf_load_data,
           buf_read_enable, buf_read_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/act_buf_scheduler.sv
// act_buf_scheduler: streams tile reads from the activation buffer one per cycle and
// blocks host writes that would land in the not-yet-read part of the active window.
module act_buf_scheduler #(
  parameter int NUM_ACTIVATIONS = 256
) (
  input logic             clk,
  input logic             rst_n,
  act_buf_scheduler_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_ACTIVATIONS);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_ACTIVATIONS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   w_len;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_done;
  logic              w_accept;
  logic              w_issue;
  logic              w_final;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_len                = bus.cmd_len > MAX_LEN ? MAX_LEN : bus.cmd_len;
    w_offset             = bus.wr_addr - r_rd_ptr;
    bus.cmd_ready        = r_state == IDLE;
    w_accept             = bus.cmd_ready && bus.cmd_valid;
    w_issue              = r_state == STREAM && !bus.stall;
    w_final              = w_issue && r_remaining == ONE;
    bus.buf_read_enable  = w_issue;
    bus.buf_read_addr    = r_rd_ptr;
    // offset is measured from the next unread entry, so offset < remaining is the unread window
    bus.wr_ready         = r_state != STREAM || {1'b0, w_offset} >= r_remaining;
    bus.buf_load_enable  = bus.wr_valid && bus.wr_ready;
    bus.buf_load_addr    = bus.wr_addr;
    bus.buf_load_data    = bus.wr_data;
    bus.out_valid        = r_out_valid;
    bus.out_last         = r_out_last;
    bus.out_data         = bus.buf_data;
    bus.done             = r_done;
    bus.busy             = r_state != IDLE;
    w_next = r_state == IDLE   ? (w_accept && w_len != '0 ? STREAM : IDLE) :
             r_state == STREAM ? (w_final ? DRAIN : STREAM) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= w_issue;
      r_out_last  <= w_final;
      // a zero-length command completes without streaming
      r_done      <= w_final || (w_accept && w_len == '0);
      if (w_accept) begin
        r_rd_ptr    <= bus.cmd_base;
        r_remaining <= w_len;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - ONE;
      end
    end
endmodule
